// File: rtl/mux_n_to_1_scan.sv
// rtl/mux_n_to_1_scan.sv - registered N-to-1 mux with manual select and round-robin auto scan
module mux_n_to_1_scan #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int DWELL = 1,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   x,
    output logic [WIDTH-1:0]     F,
    output logic [SELW-1:0]      ch,
    output logic                 valid,
    output logic                 wrap
);

    // Dwell counter is at least one bit wide so DWELL=1 still has a legal vector.
    localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);
    localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);

    logic [SELW-1:0]  cur;
    logic [CW-1:0]    cnt;
    logic             prev_mode;

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] cur_data;
    logic             sel_ok;
    logic             entering_auto;
    logic [CW-1:0]    eff_cnt;
    logic             dwell_done;
    logic             at_last;

    // Channel extraction by explicit compare so an out-of-range index never slices past x.
    always_comb begin
        sel_data = '0;
        cur_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                sel_data = x[k*WIDTH +: WIDTH];
            end
            if (cur == SELW'(k)) begin
                cur_data = x[k*WIDTH +: WIDTH];
            end
        end
    end

    // Scan bookkeeping: a fresh entry into auto mode restarts the dwell from zero.
    always_comb begin
        sel_ok        = ({1'b0, sel} < N_EXT);
        entering_auto = mode & ~prev_mode;
        eff_cnt       = entering_auto ? '0 : cnt;
        dwell_done    = (eff_cnt == CNT_LAST);
        at_last       = (cur == CH_LAST);
    end

    // Output register and scan state; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F         <= '0;
            ch        <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            cur       <= '0;
            cnt       <= '0;
            prev_mode <= 1'b0;
        end else begin
            prev_mode <= mode;
            if (!en) begin
                valid <= 1'b0;
                wrap  <= 1'b0;
            end else if (!mode) begin
                cnt  <= '0;
                wrap <= 1'b0;
                if (sel_ok) begin
                    F     <= sel_data;
                    ch    <= sel;
                    cur   <= sel;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end else begin
                F     <= cur_data;
                ch    <= cur;
                valid <= 1'b1;
                if (dwell_done) begin
                    cnt  <= '0;
                    cur  <= at_last ? '0 : cur + SELW'(1);
                    wrap <= at_last;
                end else begin
                    cnt  <= eff_cnt + CW'(1);
                    wrap <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// tb/tb_mux_n_to_1_scan.sv - scoreboard bench for mux_n_to_1_scan over three parameter sets
module tb_mux_n_to_1_scan;

    typedef struct {
        int         d;
        int         due;
        logic [7:0] f;
        logic [1:0] ch;
        logic       v;
        logic       w;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en_v    [3];
    logic        mode_v  [3];
    logic [1:0]  sel_v   [3];
    logic [31:0] x_v     [3];
    logic [7:0]  f_v     [3];
    logic [1:0]  ch_v    [3];
    logic        valid_v [3];
    logic        wrap_v  [3];

    exp_t q[$];
    int   cyc  = 0;
    int   ncmp = 0;
    int   nmis = 0;

    // Instance 0: N=4, DWELL=1
    mux_n_to_1_scan #(.WIDTH(8), .N(4), .DWELL(1)) u_a (
        .clk(clk), .rst(rst), .en(en_v[0]), .mode(mode_v[0]), .sel(sel_v[0]),
        .x(x_v[0]), .F(f_v[0]), .ch(ch_v[0]), .valid(valid_v[0]), .wrap(wrap_v[0])
    );

    // Instance 1: N=4, DWELL=3
    mux_n_to_1_scan #(.WIDTH(8), .N(4), .DWELL(3)) u_b (
        .clk(clk), .rst(rst), .en(en_v[1]), .mode(mode_v[1]), .sel(sel_v[1]),
        .x(x_v[1]), .F(f_v[1]), .ch(ch_v[1]), .valid(valid_v[1]), .wrap(wrap_v[1])
    );

    // Instance 2: N=3, DWELL=1
    mux_n_to_1_scan #(.WIDTH(8), .N(3), .DWELL(1)) u_c (
        .clk(clk), .rst(rst), .en(en_v[2]), .mode(mode_v[2]), .sel(sel_v[2]),
        .x(x_v[2][23:0]), .F(f_v[2]), .ch(ch_v[2]), .valid(valid_v[2]), .wrap(wrap_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation that has come due and compare.
    always @(negedge clk) begin : monitor
        exp_t t;
        while (q.size() > 0 && q[0].due <= cyc) begin
            t = q.pop_front();
            ncmp++;
            if ({f_v[t.d], ch_v[t.d], valid_v[t.d], wrap_v[t.d]} !== {t.f, t.ch, t.v, t.w}) begin
                nmis++;
                $display("FAIL dut%0d_cyc%0d: got F=%h ch=%0d valid=%b wrap=%b, want F=%h ch=%0d valid=%b wrap=%b",
                         t.d, t.due, f_v[t.d], ch_v[t.d], valid_v[t.d], wrap_v[t.d],
                         t.f, t.ch, t.v, t.w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int d, input logic e, input logic m, input logic [1:0] s,
                        input logic [31:0] xx, input logic [7:0] ef, input logic [1:0] ech,
                        input logic ev, input logic ew);
        exp_t t;
        en_v[d]   = e;
        mode_v[d] = m;
        sel_v[d]  = s;
        x_v[d]    = xx;
        t.d   = d;
        t.due = cyc + 1;
        t.f   = ef;
        t.ch  = ech;
        t.v   = ev;
        t.w   = ew;
        q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) en_v[i] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] b4 [4];
        logic [1:0] c;
        b4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; mode_v[i] = 1'b0; sel_v[i] = 2'd0; x_v[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reach F=A5, ch=2 then reset asynchronously mid-cycle
        step(0, 1, 0, 2'd2, 32'h44A5_2211, 8'hA5, 2'd2, 1, 0);
        @(negedge clk);
        #1;
        en_v[0] = 1'b0;
        rst = 1'b1;
        #1;
        ncmp++;
        if ({f_v[0], ch_v[0], valid_v[0], wrap_v[0]} !== {8'h00, 2'd0, 1'b0, 1'b0}) begin
            nmis++;
            $display("FAIL async_rst: got F=%h ch=%0d valid=%b wrap=%b, want all zero",
                     f_v[0], ch_v[0], valid_v[0], wrap_v[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 2'd1, 32'h4433_2211, 8'h00, 2'd0, 0, 0);
        step(0, 0, 0, 2'd1, 32'h4433_2211, 8'h00, 2'd0, 0, 0);

        // Manual sweep
        step(0, 1, 0, 2'd0, 32'h4433_2211, 8'h11, 2'd0, 1, 0);
        step(0, 1, 0, 2'd3, 32'h4433_2211, 8'h44, 2'd3, 1, 0);
        step(0, 1, 0, 2'd1, 32'h4433_2211, 8'h22, 2'd1, 1, 0);
        step(0, 1, 0, 2'd2, 32'h4433_2211, 8'h33, 2'd2, 1, 0);

        // Auto scan, DWELL=1
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            c = 2'(i % 4);
            step(0, 1, 1, 2'd0, 32'h4433_2211, b4[c], c, 1, (c == 2'd3));
        end

        // Auto scan, DWELL=3
        pulse_reset();
        for (int i = 0; i < 14; i++) begin
            c = 2'((i / 3) % 4);
            step(1, 1, 1, 2'd0, 32'h4433_2211, b4[c], c, 1, (i == 11));
        end

        // en gating, live x tracking, mode switches
        pulse_reset();
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h11, 2'd0, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h11, 2'd0, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h11, 2'd0, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h22, 2'd1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 2'd0, 32'h4433_2211, 8'h22, 2'd1, 0, 0);
        end
        step(1, 1, 1, 2'd0, 32'h4433_9911, 8'h99, 2'd1, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_7711, 8'h77, 2'd1, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h33, 2'd2, 1, 0);
        step(1, 1, 0, 2'd3, 32'h4433_2211, 8'h44, 2'd3, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h44, 2'd3, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h44, 2'd3, 1, 0);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h44, 2'd3, 1, 1);
        step(1, 1, 1, 2'd0, 32'h4433_2211, 8'h11, 2'd0, 1, 0);

        // N=3: out-of-range select holds, then scan wrap from last channel
        pulse_reset();
        step(2, 1, 0, 2'd1, 32'h00CC_BBAA, 8'hBB, 2'd1, 1, 0);
        step(2, 1, 0, 2'd3, 32'h00CC_DDAA, 8'hBB, 2'd1, 0, 0);
        step(2, 1, 0, 2'd2, 32'h00CC_DDAA, 8'hCC, 2'd2, 1, 0);
        step(2, 1, 1, 2'd0, 32'h00CC_DDAA, 8'hCC, 2'd2, 1, 1);
        step(2, 1, 1, 2'd0, 32'h00CC_DDAA, 8'hAA, 2'd0, 1, 0);
        step(2, 1, 1, 2'd0, 32'h00CC_DDAA, 8'hDD, 2'd1, 1, 0);

        for (int i = 0; i < 3; i++) en_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ncmp++;
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
